// File: rtl/rgb_arb_pkg.sv
// Shared types for the RGB LED arbiter: colour codes, FSM states and the
// colour-to-LED-line decoder.
package rgb_arb_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'b00,
    RED   = 2'b01,
    GREEN = 2'b11,
    BLUE  = 2'b10
  } color_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SHOW = 2'b01,
    GAP  = 2'b10
  } arb_state_e;

  // Returns {red, green, blue}; at most one line is ever high.
  function automatic logic [2:0] decode_rgb(input color_e c);
    logic [2:0] rgb;
    case (c)
      RED:     rgb = 3'b100;
      GREEN:   rgb = 3'b010;
      BLUE:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/rgb_rr_pick.sv
// Combinational rotating-priority picker: selects the first set bit of mask
// at or after ptr, wrapping around. Generic so other shared indicators can
// reuse it.
module rgb_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     sel,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the farthest position back to ptr so the nearest match wins.
  always_comb begin
    int j;
    j     = 0;
    sel   = {N{1'b0}};
    valid = 1'b0;
    idx   = {IDX_W{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end else begin
        j = j;
      end
      if (mask[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end else begin
        valid = valid;
      end
    end
    if (valid) begin
      sel[idx] = 1'b1;
    end else begin
      sel = {N{1'b0}};
    end
  end

endmodule

// File: rtl/rgb_led_arbiter.sv
// Round-robin arbiter sharing one RGB LED between NUM_REQ requesters.
// Each grant shows the requester's colour for max(dur,1) cycles, then a
// blank gap of GAP_CYCLES cycles, then pulses done in the first IDLE cycle.
// Optional build macro RGB_ARB_ABORT_EN: dropping req during SHOW ends the
// show early (LED low next cycle, then the normal gap and done pulse).
module rgb_led_arbiter
  import rgb_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DUR_WIDTH  = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [2*NUM_REQ-1:0]         color,
  input  logic [DUR_WIDTH*NUM_REQ-1:0] dur,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           done,
  output logic                         red,
  output logic                         green,
  output logic                         blue,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int CNT_W = (DUR_WIDTH > GAP_W) ? DUR_WIDTH : GAP_W;
  localparam logic [CNT_W-1:0] GAP_LAST =
    (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : {CNT_W{1'b0}};

  arb_state_e         state;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   dur_l;

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   pick_sel;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [1:0]           pick_color;
  logic [DUR_WIDTH-1:0] pick_dur;
  logic                 show_last;
  logic                 show_end;

  // A requester finishing this cycle cannot be re-granted before it drops req.
  assign eligible = req & ~done;

  rgb_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .mask  (eligible),
    .ptr   (ptr),
    .sel   (pick_sel),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Mux out the picked requester's colour and duration fields.
  always_comb begin
    pick_color = 2'b00;
    pick_dur   = {DUR_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_color = color[2*i +: 2];
        pick_dur   = dur[DUR_WIDTH*i +: DUR_WIDTH];
      end else begin
        pick_color = pick_color;
      end
    end
  end

  assign show_last = (cnt == (dur_l - CNT_W'(1)));
  assign busy      = (state != IDLE);

`ifdef RGB_ARB_ABORT_EN
  logic [IDX_W-1:0] cur_idx;
  assign show_end = show_last | ~req[cur_idx];

  // Remember which requester holds the LED so its req can cut the show short.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_idx <= {IDX_W{1'b0}};
    end else if (state == IDLE && pick_valid) begin
      cur_idx <= pick_idx;
    end else begin
      cur_idx <= cur_idx;
    end
  end
`else
  assign show_end = show_last;
`endif

  // Arbitration FSM with registered grant, done and LED lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= {IDX_W{1'b0}};
      cnt   <= {CNT_W{1'b0}};
      dur_l <= {CNT_W{1'b0}};
      gnt   <= {NUM_REQ{1'b0}};
      done  <= {NUM_REQ{1'b0}};
      {red, green, blue} <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          done <= {NUM_REQ{1'b0}};
          if (pick_valid) begin
            state <= SHOW;
            gnt   <= pick_sel;
            cnt   <= {CNT_W{1'b0}};
            dur_l <= (pick_dur == {DUR_WIDTH{1'b0}}) ? CNT_W'(1) : CNT_W'(pick_dur);
            {red, green, blue} <= decode_rgb(color_e'(pick_color));
            ptr   <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}}
                                                       : pick_idx + IDX_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        SHOW: begin
          if (show_end) begin
            {red, green, blue} <= 3'b000;
            cnt <= {CNT_W{1'b0}};
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
              gnt   <= {NUM_REQ{1'b0}};
              done  <= gnt;
            end else begin
              state <= GAP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= {CNT_W{1'b0}};
            gnt   <= {NUM_REQ{1'b0}};
            done  <= gnt;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= {CNT_W{1'b0}};
          gnt   <= {NUM_REQ{1'b0}};
          done  <= {NUM_REQ{1'b0}};
          {red, green, blue} <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed, table-driven bench for rgb_led_arbiter (NUM_REQ=4, DUR_WIDTH=8,
// GAP_CYCLES=2). Observed word is {gnt[3:0], done[3:0], red, green, blue, busy}.
module tb_rgb_led_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  color;
  logic [31:0] dur;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        red;
  logic        green;
  logic        blue;
  logic        busy;

  int n_vec;
  int n_err;

  rgb_led_arbiter #(.NUM_REQ(4), .DUR_WIDTH(8), .GAP_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .color (color),
    .dur   (dur),
    .gnt   (gnt),
    .done  (done),
    .red   (red),
    .green (green),
    .blue  (blue),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  color;
    logic [31:0] dur;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [11:0] obs();
    return {gnt, done, red, green, blue, busy};
  endfunction

  task automatic add(input string nm, input logic r, input logic [3:0] q,
                     input logic [7:0] c, input logic [31:0] d,
                     input logic [11:0] e);
    vec_t v;
    v.name = nm; v.rst = r; v.req = q; v.color = c; v.dur = d; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got gnt/done/rgb/busy=%b_%b_%b_%b want %b_%b_%b_%b", nm,
               act[11:8], act[7:4], act[3:1], act[0], exp[11:8], exp[7:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int red_cnt;
    int done_at;
    logic done_seen;
    int exp_red;
    int exp_done_at;

    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    req   = 4'b0000;
    color = 8'h00;
    dur   = 32'h0;

    // Reset release with no requests: everything stays low.
    add("rst",     1'b1, 4'b0000, 8'h00, 32'h0, 12'b0000_0000_000_0);
    add("idle0",   1'b0, 4'b0000, 8'h00, 32'h0, 12'b0000_0000_000_0);
    add("idle1",   1'b0, 4'b0000, 8'h00, 32'h0, 12'b0000_0000_000_0);
    add("idle2",   1'b0, 4'b0000, 8'h00, 32'h0, 12'b0000_0000_000_0);
    // Requester 1, RED, dur 3: 3 red cycles, 2 gap cycles, done pulse.
    add("r1_s0",   1'b0, 4'b0010, 8'b00000100, 32'h00000300, 12'b0010_0000_100_1);
    add("r1_s1",   1'b0, 4'b0010, 8'b00000100, 32'h00000300, 12'b0010_0000_100_1);
    add("r1_s2",   1'b0, 4'b0010, 8'b00000100, 32'h00000300, 12'b0010_0000_100_1);
    add("r1_g0",   1'b0, 4'b0010, 8'b00000100, 32'h00000300, 12'b0010_0000_000_1);
    add("r1_g1",   1'b0, 4'b0010, 8'b00000100, 32'h00000300, 12'b0010_0000_000_1);
    add("r1_done", 1'b0, 4'b0010, 8'b00000100, 32'h00000300, 12'b0000_0010_000_0);
    add("r1_mask", 1'b0, 4'b0010, 8'b00000100, 32'h00000300, 12'b0000_0000_000_0);
    add("r1_off",  1'b0, 4'b0000, 8'b00000100, 32'h00000300, 12'b0000_0000_000_0);
    // Requesters 0,2,3 (RED, GREEN, BLUE) dur 1: order 0,2,3,0.
    add("rr_rst",  1'b1, 4'b0000, 8'b10110001, 32'h01010101, 12'b0000_0000_000_0);
    add("rr_g0",   1'b0, 4'b1101, 8'b10110001, 32'h01010101, 12'b0001_0000_100_1);
    add("rr_p0a",  1'b0, 4'b1101, 8'b10110001, 32'h01010101, 12'b0001_0000_000_1);
    add("rr_p0b",  1'b0, 4'b1101, 8'b10110001, 32'h01010101, 12'b0001_0000_000_1);
    add("rr_d0",   1'b0, 4'b1101, 8'b10110001, 32'h01010101, 12'b0000_0001_000_0);
    add("rr_g2",   1'b0, 4'b1101, 8'b10110001, 32'h01010101, 12'b0100_0000_010_1);
    add("rr_p2a",  1'b0, 4'b1101, 8'b10110001, 32'h01010101, 12'b0100_0000_000_1);
    add("rr_p2b",  1'b0, 4'b1101, 8'b10110001, 32'h01010101, 12'b0100_0000_000_1);
    add("rr_d2",   1'b0, 4'b1101, 8'b10110001, 32'h01010101, 12'b0000_0100_000_0);
    add("rr_g3",   1'b0, 4'b1101, 8'b10110001, 32'h01010101, 12'b1000_0000_001_1);
    add("rr_p3a",  1'b0, 4'b1101, 8'b10110001, 32'h01010101, 12'b1000_0000_000_1);
    add("rr_p3b",  1'b0, 4'b1101, 8'b10110001, 32'h01010101, 12'b1000_0000_000_1);
    add("rr_d3",   1'b0, 4'b1101, 8'b10110001, 32'h01010101, 12'b0000_1000_000_0);
    add("rr_g0b",  1'b0, 4'b1101, 8'b10110001, 32'h01010101, 12'b0001_0000_100_1);
    add("rr_p0c",  1'b0, 4'b0000, 8'b10110001, 32'h01010101, 12'b0001_0000_000_1);
    add("rr_p0d",  1'b0, 4'b0000, 8'b10110001, 32'h01010101, 12'b0001_0000_000_1);
    add("rr_d0b",  1'b0, 4'b0000, 8'b10110001, 32'h01010101, 12'b0000_0001_000_0);
    add("rr_off",  1'b0, 4'b0000, 8'b10110001, 32'h01010101, 12'b0000_0000_000_0);
    // dur 0 on BLUE behaves as dur 1.
    add("d0_rst",  1'b1, 4'b0000, 8'b00000010, 32'h00000000, 12'b0000_0000_000_0);
    add("d0_show", 1'b0, 4'b0001, 8'b00000010, 32'h00000000, 12'b0001_0000_001_1);
    add("d0_g0",   1'b0, 4'b0000, 8'b00000010, 32'h00000000, 12'b0001_0000_000_1);
    add("d0_g1",   1'b0, 4'b0000, 8'b00000010, 32'h00000000, 12'b0001_0000_000_1);
    add("d0_done", 1'b0, 4'b0000, 8'b00000010, 32'h00000000, 12'b0000_0001_000_0);
    add("d0_off",  1'b0, 4'b0000, 8'b00000010, 32'h00000000, 12'b0000_0000_000_0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst;
      req   = tbl[i].req;
      color = tbl[i].color;
      dur   = tbl[i].dur;
      step();
      check(tbl[i].name, obs(), tbl[i].exp);
    end

    // Maximum duration: dur=8'hFF gives 255 red cycles, no wrap.
    reset = 1'b1; req = 4'b0000; step();
    reset = 1'b0; req = 4'b0001; color = 8'b00000001; dur = 32'h000000FF;
    step();
    red_cnt = 0; done_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (red) red_cnt++;
      if (done[0]) begin
        done_seen = 1'b1;
        break;
      end
      step();
    end
    req = 4'b0000;
    check_int("maxdur_red_cycles", red_cnt, 255);
    check_int("maxdur_done_seen", int'(done_seen), 1);
    step();

    // Reset in the middle of a GREEN show: immediate clear, no done, ptr back to 0.
    reset = 1'b1; step();
    reset = 1'b0; req = 4'b0100; color = 8'b00110000; dur = 32'h000A0000;
    step(); step(); step();
    check("mid_green", obs(), 12'b0100_0000_010_1);
    reset = 1'b1;
    #1;
    check("mid_rst_async", obs(), 12'b0000_0000_000_0);
    step();
    check("mid_rst_hold", obs(), 12'b0000_0000_000_0);
    reset = 1'b0; req = 4'b0101; color = 8'b00110011; dur = 32'h000A000A;
    step();
    check("mid_rst_prio0", obs(), 12'b0001_0000_010_1);
    req = 4'b0000;

    // Drop req after 3 SHOW cycles of a dur-10 RED show.
    reset = 1'b1; step();
    reset = 1'b0; req = 4'b0001; color = 8'b00000001; dur = 32'h0000000A;
    step();
    red_cnt = 0; done_seen = 1'b0; done_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (red) red_cnt++;
      if (red_cnt == 3) req = 4'b0000;
      if (done[0]) begin
        done_seen = 1'b1;
        done_at = i;
        break;
      end
      step();
    end
`ifdef RGB_ARB_ABORT_EN
    exp_red = 3;
`else
    exp_red = 10;
`endif
    exp_done_at = exp_red + 2;
    check_int("drop_red_cycles", red_cnt, exp_red);
    check_int("drop_done_seen", int'(done_seen), 1);
    check_int("drop_done_cycle", done_at, exp_done_at);
    step();
    check("drop_idle", obs(), 12'b0000_0000_000_0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
